// File: rtl/reg_seq_pkg.sv
// Shared types for the MOV8 register-move sequencer: register ids, sequencer states
// and the register count.
package reg_seq_pkg;

    localparam int unsigned NUM_REGS = 8;

    typedef enum logic [2:0] {
        RegA  = 3'd0,
        RegB  = 3'd1,
        RegC  = 3'd2,
        RegD  = 3'd3,
        RegM1 = 3'd4,
        RegM2 = 3'd5,
        RegX  = 3'd6,
        RegY  = 3'd7
    } reg_id_t;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StLoad,
        StHold,
        StDone
    } seq_state_t;

endpackage

// File: rtl/reg_id_decode.sv
// Register id to one-hot strobe decoder; bit index equals the register id.
module reg_id_decode
    import reg_seq_pkg::*;
(
    input  reg_id_t               id_i,
    output logic [NUM_REGS-1:0]   onehot_o
);

    always_comb begin
        onehot_o       = '0;
        onehot_o[id_i] = 1'b1;
    end

endmodule

// File: rtl/reg_move_sequencer.sv
// Break-before-make sequencer for 8-bit register-to-register moves (select, load, hold, done).
// Optional clear moves are enabled by defining REG_MOVE_SEQUENCER_CLEAR_EN.
module reg_move_sequencer
    import reg_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOAD_CYCLES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_src,
    input  logic [2:0]          req_dst,
    input  logic                req_clr,
    output logic [NUM_REGS-1:0] sel,
    output logic [NUM_REGS-1:0] ld,
    output logic                busy,
    output logic                done
);

    localparam int unsigned MaxCycles =
        (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
    localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    seq_state_t          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    reg_id_t             src_q, src_d, dst_q, dst_d;
    logic [NUM_REGS-1:0] sel_q, sel_d, ld_q, ld_d, sel_dec, ld_dec;
    logic                busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic                accept, clr_in, clr_q, clr_d;

    assign accept = req_valid && ready_q;

`ifdef REG_MOVE_SEQUENCER_CLEAR_EN
    assign clr_in = req_clr;

    always_comb begin
        clr_d = clr_q;
        if (accept) clr_d = req_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clr_q <= 1'b0;
        else     clr_q <= clr_d;
    end
`else
    logic unused_clr;
    assign unused_clr = req_clr;
    assign clr_in     = 1'b0;
    assign clr_q      = 1'b0;
    assign clr_d      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    src_d = reg_id_t'(req_src);
                    dst_d = reg_id_t'(req_dst);
                    if (clr_in)                   state_d = StLoad;
                    else if (req_src == req_dst) state_d = StDone;
                    else                          state_d = StSel;
                end
            end
            StSel: begin
                if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (cnt_q == CntW'(LOAD_CYCLES - 1)) begin
                    // A clear never drove the bus, so there is no select to release.
                    state_d = clr_q ? StDone : StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                state_d = StDone;
                cnt_d   = '0;
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    reg_id_decode u_sel_decode (
        .id_i     (src_d),
        .onehot_o (sel_dec)
    );

    reg_id_decode u_ld_decode (
        .id_i     (dst_d),
        .onehot_o (ld_dec)
    );

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        sel_d   = '0;
        ld_d    = '0;
        if (!clr_d && (state_d inside {StSel, StLoad, StHold})) sel_d = sel_dec;
        if (state_d == StLoad) ld_d = ld_dec;
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            src_q   <= RegA;
            dst_q   <= RegA;
            sel_q   <= '0;
            ld_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            sel_q   <= sel_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign sel       = sel_q;
    assign ld        = ld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_ready = ready_q;

endmodule

// File: doc/reg_move_sequencer.md
# reg_move_sequencer

Sequencer for the register unit's 8-bit register-to-register moves (MOV8). It accepts one move request at a time (source, destination), then drives the per-register select and load strobes in a fixed break-before-make order. The source therefore drives the data bus and settles before the destination latches it. It sits between the instruction sequencer and the eight register blocks (A, B, C, D, M1, M2, X, Y), and is the only block that asserts their select and load controls.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles the source select is held before load asserts (≥1)
- LOAD_CYCLES, 2, cycles load and select are held together (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  move request present
- req_ready  out  1  sequencer can accept a request
- req_src  in  3  source register id
- req_dst  in  3  destination register id
- req_clr  in  1  clear destination, with no source driven (see Configuration)
- sel  out  8  one-hot select strobes, bit index = register id
- ld  out  8  one-hot load strobes, bit index = register id
- busy  out  1  a move is in progress
- done  out  1  one-cycle pulse when a move completes

Register ids: 0 A, 1 B, 2 C, 3 D, 4 M1, 5 M2, 6 X, 7 Y.

## Operation
- States: IDLE, SEL, LOAD, HOLD, DONE.
- IDLE:
  - req_ready=1; sel, ld, busy and done are all 0.
  - On req_valid && req_ready, capture src, dst and clr, then go to SEL.
- SEL:
  - sel[src]=1 for SETTLE_CYCLES cycles, then go to LOAD.
- LOAD:
  - sel[src]=1 and ld[dst]=1 for LOAD_CYCLES cycles, then go to HOLD.
- HOLD:
  - sel[src]=1 and ld=0 for exactly 1 cycle, then go to DONE.
  - This ensures load falls before select.
- DONE:
  - done=1 for 1 cycle with sel=ld=0, then return to IDLE.
- busy=1 in SEL, LOAD, HOLD and DONE.
- src==dst (with clr=0) is a no-op: go IDLE→DONE directly. No sel or ld is ever asserted, and done still pulses.
- Captured fields are frozen while busy; input changes have no effect until the next accept.
- At most one bit of sel and at most one bit of ld is set at any time.
- A phase counter, wide enough for max(SETTLE_CYCLES, LOAD_CYCLES), resets to 0 on every state entry.

## Timing
- All outputs are registered. Reset value of every output is 0, except req_ready=1.
- Assertion of rst clears state to IDLE and sel, ld, busy and done to 0 immediately (asynchronously), including mid-move. A partially loaded register is not restored.
- Accept at cycle 0. With defaults:
  - sel rises at cycle 1.
  - ld spans cycles 3–4.
  - HOLD is cycle 5.
  - done is at cycle 6.
  - req_ready returns at cycle 7.
- General latency from accept to done is SETTLE_CYCLES + LOAD_CYCLES + 2 cycles.
- No-op move: done at cycle 1, req_ready at cycle 2.
- No back-to-back accept: req_ready is 0 during the DONE cycle.

## Configuration
- Macro: REG_MOVE_SEQUENCER_CLEAR_EN.
- Defined:
  - req_clr=1 is captured at accept and performs a clear move of the form IDLE→LOAD→DONE.
  - ld[dst] is held for LOAD_CYCLES with sel=0 throughout, so the destination loads 0 from the undriven bus.
  - src is ignored, and src==dst does not make it a no-op.
- Undefined:
  - req_clr is ignored and all requests are ordinary moves.
  - No clear logic is present in the netlist.

## Structure
- Shared package reg_seq_pkg holds:
  - typedef reg_id_t (3-bit enum A..Y)
  - typedef seq_state_t (IDLE, SEL, LOAD, HOLD, DONE)
  - constant NUM_REGS=8
- One sub-module, reg_id_decode, converts reg_id_t to an 8-bit one-hot value; it is instantiated twice (sel and ld).
- The state machine and phase counter live in the top module.

## Test plan
- Reset value: rst high for 3 cycles → req_ready=1 and sel=ld=busy=done=0; after release, state is IDLE.
- Move B→C (src=1, dst=2), defaults:
  - sel=8'h02 from cycle 1 to cycle 5
  - ld=8'h04 on cycles 3–4
  - done on cycle 6
  - req_ready on cycle 7
- No-op src=dst=6 (X): no sel or ld activity; done on cycle 1; busy high only on cycle 1.
- Request fields change mid-move: accept M1→Y, then drive src=0, dst=0 while busy → strobes stay sel=8'h10, ld=8'h80.
- Reset mid-move: assert rst during LOAD → sel and ld drop to 0 in the same cycle; after release, req_ready=1 and there is no done pulse.
- Clear move, with REG_MOVE_SEQUENCER_CLEAR_EN defined: req_clr=1, dst=3 → ld=8'h08 for 2 cycles with sel=0, then done.
  - Same stimulus without the macro: behaves as an ordinary move from req_src.
